// File: rtl/alu_seq.sv
// alu_seq: command sequencer that drives an external 8-bit combinational ALU.
// Commands read operands from a small register file, the ALU result is
// written back to the destination register and returned on a response
// channel. Each command walks IDLE -> EXEC -> RESP -> IDLE.
// Optional build macro ALU_SEQ_CHECK_EN adds a reference model that raises
// the sticky chk_err_o flag when the ALU answer disagrees with it.
`timescale 1ns/1ps

module alu_seq #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [AW-1:0]     cmd_rd_i,
    input  logic [AW-1:0]     cmd_rs1_i,
    input  logic [AW-1:0]     cmd_rs2_i,
    input  logic              cmd_use_imm_i,
    input  logic [DATA_W-1:0] cmd_imm_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [AW-1:0]     rsp_rd_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              chk_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_aluA;
    logic [DATA_W-1:0]   r_aluB;
    logic [2:0]          r_aluOp;
    logic [AW-1:0]       r_rd;
    logic                r_rspValid;
    logic [DATA_W-1:0]   r_rspData;
    logic [AW-1:0]       r_rspRd;
    logic                w_accept;

    assign cmd_ready_o = (r_state == IDLE);
    assign w_accept    = cmd_valid_i && (r_state == IDLE);
    assign alu_a_o     = r_aluA;
    assign alu_b_o     = r_aluB;
    assign alu_op_o    = r_aluOp;
    assign rsp_valid_o = r_rspValid;
    assign rsp_data_o  = r_rspData;
    assign rsp_rd_o    = r_rspRd;
    assign dbg_data_o  = r_regs[dbg_addr_i];

    // State register; reset abandons whatever command is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: EXEC always lasts one cycle, RESP waits for the consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (cmd_valid_i) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (rsp_ready_i) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: latch operands at accept, write back and publish in EXEC, retire on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluOp    <= '0;
            r_rd       <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspRd    <= '0;
        end else begin
            if (w_accept) begin
                r_aluOp <= cmd_op_i;
                r_aluA  <= r_regs[cmd_rs1_i];
                r_aluB  <= cmd_use_imm_i ? cmd_imm_i : r_regs[cmd_rs2_i];
                r_rd    <= cmd_rd_i;
            end
            if (r_state == EXEC) begin
                r_regs[r_rd] <= alu_res_i;
                r_rspData    <= alu_res_i;
                r_rspRd      <= r_rd;
                r_rspValid   <= 1'b1;
            end
            if ((r_state == RESP) && rsp_ready_i) begin
                r_rspValid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQL = 3'b111;

    logic [DATA_W-1:0] w_expRes;
    logic              r_chkErr;

    // Reference ALU evaluated on the operands currently presented to the external ALU.
    always_comb begin
        w_expRes = '0;
        case (r_aluOp)
            OP_ADD:  w_expRes = r_aluA + r_aluB;
            OP_SUB:  w_expRes = r_aluA - r_aluB;
            OP_SLL:  w_expRes = r_aluA << r_aluB[2:0];
            OP_LSR:  w_expRes = r_aluA >> r_aluB[2:0];
            OP_AND:  w_expRes = r_aluA & r_aluB;
            OP_OR:   w_expRes = r_aluA | r_aluB;
            OP_XOR:  w_expRes = r_aluA ^ r_aluB;
            OP_EQL:  w_expRes = {{(DATA_W-1){1'b0}}, (r_aluA == r_aluB)};
            default: w_expRes = '0;
        endcase
    end

    // Sticky mismatch flag, sampled only while the ALU result is meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chkErr <= 1'b0;
        end else if ((r_state == EXEC) && (alu_res_i != w_expRes)) begin
            r_chkErr <= 1'b1;
        end
    end

    assign chk_err_o = r_chkErr;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule
